apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
- Parametrised, queued APB4 master.
- Accepts read/write commands through a valid/ready command port into a command FIFO and executes them as APB SETUP/ACCESS transfers.
- Returns one response per command (read data, error flag) on a valid/ready response port, buffered in a response FIFO.
- Sits between an internal command source (CPU bridge, DMA, test sequencer) and an APB slave segment.

Parameters:
- DATA_WIDTH, 32, APB data width; multiple of 8.
- ADDR_WIDTH, 12, APB address width.
- CMD_DEPTH, 4, command FIFO entries; power of 2, >=2.
- RSP_DEPTH, 2, response FIFO entries; power of 2, >=2.
- TIMEOUT_CYCLES, 255, ACCESS wait limit used only with APB_MST_TIMEOUT_EN; >=1.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- cmd_vld  input  1  command valid
- cmd_rdy  output  1  command FIFO not full
- cmd_write  input  1  1=write, 0=read
- cmd_addr  input  ADDR_WIDTH  transfer address
- cmd_wdata  input  DATA_WIDTH  write data
- cmd_strb  input  DATA_WIDTH/8  write byte strobes; ignored for reads
- rsp_vld  output  1  response FIFO not empty
- rsp_rdy  input  1  response consumer ready
- rsp_write  output  1  response belongs to a write
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes
- rsp_err  output  1  pslverr (or timeout) for this transfer
- busy  output  1  any command queued, in flight, or response pending
- psel, penable, pwrite  output  1 each  APB control
- paddr  output  ADDR_WIDTH  APB address
- pwdata  output  DATA_WIDTH  APB write data
- pstrb  output  DATA_WIDTH/8  APB4 strobes; all 0 on reads
- prdata  input  DATA_WIDTH  APB read data
- pready, pslverr  input  1 each  APB completion / error

Behaviour:
- Reset: both FIFOs empty, FSM IDLE, all APB outputs 0, rsp_vld=0, busy=0, cmd_rdy=1 one cycle after rstn release (combinational !full). Reset mid-transfer aborts immediately; the slave sees psel drop and no response is produced.
- Command FIFO:
  - Push on cmd_vld&&cmd_rdy.
  - Simultaneous push and pop when full is not allowed: cmd_rdy uses the registered full flag only.
  - Pointers wrap modulo CMD_DEPTH.
- Response FIFO:
  - Pop on rsp_vld&&rsp_rdy.
  - Push on transfer completion.
  - Push and pop in the same cycle keeps the count unchanged.
- Launch condition L = cmd FIFO not empty && (rsp_count + push - pop) < RSP_DEPTH, evaluated in IDLE or on completing ACCESS. This guarantees a response slot for every started transfer, so the master never stalls after pready.
- FSM:
  - IDLE: L -> SETUP (pop command, register paddr/pwrite/pwdata/pstrb); else stay.
  - SETUP: psel=1, penable=0; unconditionally -> ACCESS next cycle.
  - ACCESS: psel=1, penable=1; hold all APB outputs stable while pready=0.
  - ACCESS with pready=1 (completion):
    - Push {pwrite, pwrite?0:prdata, pslverr}.
    - If L: -> SETUP (back-to-back, psel stays 1, penable drops).
    - Else: -> IDLE (psel=0, penable=0).
- Latency: command accepted at edge N, FIFO previously empty → psel=1 from N+1 edge, penable from N+2, response visible the cycle after the pready sample. Minimum 3 cycles cmd to rsp_vld.
- Throughput: one transfer per 2 cycles at zero wait states, provided responses drain.
- In IDLE: paddr, pwdata, pstrb, pwrite hold their last values; only psel/penable are driven 0.
- pslverr is sampled only with psel&&penable&&pready; ignored otherwise.
- busy = cmd non-empty || state!=IDLE || rsp non-empty.

Optional Feature:
- Macro APB_MST_TIMEOUT_EN.
- Defined:
  - Counter clears on SETUP and increments each ACCESS cycle with pready=0.
  - On reaching TIMEOUT_CYCLES, the transfer is aborted: psel/penable to 0, -> IDLE (no back-to-back launch that cycle).
  - Response pushed with rsp_err=1, rsp_rdata=0.
  - pready arriving in the same cycle as the count reaches the limit wins as a normal completion.
- Undefined: no counter; ACCESS waits indefinitely for pready.

Test Plan:
- Reset, then write addr 0x010, data 0xA5A5_5A5A, strb 0xF, pready tied 1 -> psel at cycle 1, penable at cycle 2, one response rsp_write=1 rsp_err=0 rsp_rdata=0.
- Read 0x020, slave returns 0x1234_5678 after 3 wait states -> paddr/psel/penable stable for 4 ACCESS cycles; rsp_rdata=0x1234_5678.
- Push 4 commands with rsp_rdy=0 and RSP_DEPTH=2 -> exactly 2 transfers run, FSM parks in IDLE, cmd_rdy reflects fill level; raising rsp_rdy resumes with back-to-back SETUP, 4 responses in order.
- Read with pslverr=1 at completion -> rsp_err=1; the following write completes normally with rsp_err=0.
- Fill the command FIFO (CMD_DEPTH=4) while the slave stalls -> cmd_rdy=0 after 4 accepted commands; extra cmd_vld ignored; no command lost or duplicated.
- With APB_MST_TIMEOUT_EN, TIMEOUT_CYCLES=8, pready held 0 -> psel drops after 8 ACCESS cycles, rsp_err=1, next command proceeds; assert rstn mid-ACCESS -> all outputs 0 immediately, no response.

Source files
------------

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: queued APB4 master.
//   Commands enter a CMD_DEPTH-entry FIFO through a valid/ready port. Each one
//   runs as an APB SETUP/ACCESS transfer. The master returns one response per
//   command (write flag, read data, error) through a RSP_DEPTH-entry FIFO.
//   A transfer starts only when a response slot is already reserved for it.
//   Because of that, completion never has to wait after pready.
// Optional build macro: APB_MST_TIMEOUT_EN. When it is defined, an ACCESS
//   phase with no pready for TIMEOUT_CYCLES cycles is aborted and answered
//   with rsp_err=1.
// Ports:
//   clk, rstn                          clock, async active-low reset
//   cmd_vld/cmd_rdy                    command handshake (rdy = FIFO not full)
//   cmd_write/addr/wdata/strb          command payload
//   rsp_vld/rsp_rdy                    response handshake (vld = FIFO not empty)
//   rsp_write/rsp_rdata/rsp_err        response payload
//   busy                               queued, in-flight or pending work
//   psel/penable/pwrite/paddr/pwdata/pstrb   APB4 request outputs
//   prdata/pready/pslverr              APB4 completion inputs
module apb_cmd_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int CMD_DEPTH      = 4,
  parameter int RSP_DEPTH      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cmd_vld,
  output logic                    cmd_rdy,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_vld,
  input  logic                    rsp_rdy,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int SW  = DATA_WIDTH / 8;
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);

  // Reject illegal parameter sets at elaboration.
  if ((DATA_WIDTH % 8) != 0 || CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 ||
      RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("apb_cmd_master: illegal parameter set");
  end

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SETUP = 2'd1, ST_ACCESS = 2'd2} state_t;

  state_t r_state, w_state_nxt;

  // Command FIFO storage and pointers
  logic                  r_cmd_write [CMD_DEPTH];
  logic [ADDR_WIDTH-1:0] r_cmd_addr  [CMD_DEPTH];
  logic [DATA_WIDTH-1:0] r_cmd_wdata [CMD_DEPTH];
  logic [SW-1:0]         r_cmd_strb  [CMD_DEPTH];
  logic [CAW-1:0]        r_cmd_wp, r_cmd_rp;
  logic [CAW:0]          r_cmd_cnt;

  // Response FIFO storage and pointers
  logic                  r_rsp_write [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] r_rsp_rdata [RSP_DEPTH];
  logic                  r_rsp_err   [RSP_DEPTH];
  logic [RAW-1:0]        r_rsp_wp, r_rsp_rp;
  logic [RAW:0]          r_rsp_cnt;

  logic                  w_cmd_push, w_cmd_pop, w_cmd_full, w_cmd_empty;
  logic                  w_rsp_push, w_rsp_pop;
  logic [RAW+1:0]        w_rsp_next;
  logic                  w_can_launch, w_launch;
  logic                  w_complete, w_abort;
  logic [DATA_WIDTH-1:0] w_push_rdata;
  logic                  w_push_err;

  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [SW-1:0]         r_pstrb;

  assign w_cmd_full  = (r_cmd_cnt == (CAW+1)'(CMD_DEPTH));
  assign w_cmd_empty = (r_cmd_cnt == '0);
  assign cmd_rdy     = ~w_cmd_full;
  assign w_cmd_push  = cmd_vld & ~w_cmd_full;
  assign w_cmd_pop   = w_launch;

  assign rsp_vld     = (r_rsp_cnt != '0);
  assign w_rsp_pop   = rsp_vld & rsp_rdy;
  assign w_complete  = (r_state == ST_ACCESS) & pready;
  assign w_rsp_push  = w_complete | w_abort;

  // Occupancy the response FIFO will have after this edge. A new transfer
  // may start only if a slot is still free at that point.
  assign w_rsp_next   = (RAW+2)'(r_rsp_cnt) + (RAW+2)'(w_rsp_push) - (RAW+2)'(w_rsp_pop);
  assign w_can_launch = ~w_cmd_empty & (w_rsp_next < (RAW+2)'(RSP_DEPTH));

  // An abort never carries slave data. Only a read completion captures prdata.
  assign w_push_rdata = (w_complete & ~r_pwrite) ? prdata : '0;
  assign w_push_err   = w_complete ? pslverr : 1'b1;

`ifdef APB_MST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt;

  // The limit is reached in the cycle that holds count TIMEOUT_CYCLES-1, which
  // is the TIMEOUT_CYCLES-th ACCESS cycle. A pready in that cycle still wins.
  assign w_abort = (r_state == ST_ACCESS) & ~pready & (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // ACCESS wait counter: cleared in SETUP, counts stalled ACCESS cycles
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                r_tmo_cnt <= '0;
    else if (r_state == ST_SETUP)             r_tmo_cnt <= '0;
    else if (r_state == ST_ACCESS && !pready) r_tmo_cnt <= r_tmo_cnt + TW'(1);
    else                                      r_tmo_cnt <= r_tmo_cnt;
  end
`else
  assign w_abort = 1'b0;
`endif

  // FSM next state and launch decision
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_can_launch) begin
          w_launch    = 1'b1;
          w_state_nxt = ST_SETUP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: w_state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (pready && w_can_launch) begin
          w_launch    = 1'b1;
          w_state_nxt = ST_SETUP;
        end else if (pready || w_abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ACCESS;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // APB request registers: loaded at launch, otherwise hold their last value
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pstrb  <= '0;
    end else if (w_launch) begin
      r_pwrite <= r_cmd_write[r_cmd_rp];
      r_paddr  <= r_cmd_addr[r_cmd_rp];
      r_pwdata <= r_cmd_wdata[r_cmd_rp];
      r_pstrb  <= r_cmd_write[r_cmd_rp] ? r_cmd_strb[r_cmd_rp] : '0;
    end else begin
      r_pwrite <= r_pwrite;
      r_paddr  <= r_paddr;
      r_pwdata <= r_pwdata;
      r_pstrb  <= r_pstrb;
    end
  end

  // Command FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cmd_wp  <= '0;
      r_cmd_rp  <= '0;
      r_cmd_cnt <= '0;
    end else begin
      r_cmd_wp  <= w_cmd_push ? r_cmd_wp + CAW'(1) : r_cmd_wp;
      r_cmd_rp  <= w_cmd_pop  ? r_cmd_rp + CAW'(1) : r_cmd_rp;
      r_cmd_cnt <= r_cmd_cnt + (CAW+1)'(w_cmd_push) - (CAW+1)'(w_cmd_pop);
    end
  end

  // Command FIFO storage write
  always_ff @(posedge clk) begin
    if (w_cmd_push) begin
      r_cmd_write[r_cmd_wp] <= cmd_write;
      r_cmd_addr[r_cmd_wp]  <= cmd_addr;
      r_cmd_wdata[r_cmd_wp] <= cmd_wdata;
      r_cmd_strb[r_cmd_wp]  <= cmd_strb;
    end
  end

  // Response FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rsp_wp  <= '0;
      r_rsp_rp  <= '0;
      r_rsp_cnt <= '0;
    end else begin
      r_rsp_wp  <= w_rsp_push ? r_rsp_wp + RAW'(1) : r_rsp_wp;
      r_rsp_rp  <= w_rsp_pop  ? r_rsp_rp + RAW'(1) : r_rsp_rp;
      r_rsp_cnt <= r_rsp_cnt + (RAW+1)'(w_rsp_push) - (RAW+1)'(w_rsp_pop);
    end
  end

  // Response FIFO storage write
  always_ff @(posedge clk) begin
    if (w_rsp_push) begin
      r_rsp_write[r_rsp_wp] <= r_pwrite;
      r_rsp_rdata[r_rsp_wp] <= w_push_rdata;
      r_rsp_err[r_rsp_wp]   <= w_push_err;
    end
  end

  assign rsp_write = r_rsp_write[r_rsp_rp];
  assign rsp_rdata = r_rsp_rdata[r_rsp_rp];
  assign rsp_err   = r_rsp_err[r_rsp_rp];

  assign psel    = (r_state == ST_SETUP) | (r_state == ST_ACCESS);
  assign penable = (r_state == ST_ACCESS);
  assign pwrite  = r_pwrite;
  assign paddr   = r_paddr;
  assign pwdata  = r_pwdata;
  assign pstrb   = r_pstrb;
  assign busy    = ~w_cmd_empty | (r_state != ST_IDLE) | rsp_vld;

endmodule

// File: tb/tb_apb_cmd_master.sv
module tb_apb_cmd_master;

`ifdef APB_MST_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_vld = 1'b0, cmd_rdy, cmd_write = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_vld, rsp_rdy = 1'b0, rsp_write, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata = '0;
  logic [3:0]  pstrb;
  logic        pready = 1'b0, pslverr = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Slave model controls
  int          slv_ws = 0;
  int          ws_cnt = 0;
  logic        slv_stall = 1'b0;
  logic        slv_err = 1'b0;
  logic        slv_fixed = 1'b0;
  logic [31:0] slv_rdata = '0;

  logic [11:0] log_addr[$];
  logic        log_write[$];

  apb_cmd_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(12), .CMD_DEPTH(4), .RSP_DEPTH(2), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  // APB slave: drives completion on the falling edge and logs completed transfers
  always @(negedge clk) begin
    if (!rstn || !(psel && penable)) begin
      ws_cnt = 0;
      pready = 1'b0;
    end else begin
      pready = !slv_stall && (ws_cnt >= slv_ws);
      ws_cnt++;
    end
    prdata  = slv_fixed ? slv_rdata : {20'hDA7A0, paddr};
    pslverr = slv_err && pready;
    if (pready) begin
      log_addr.push_back(paddr);
      log_write.push_back(pwrite);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_vld = 1'b1;
    while (!cmd_rdy && n < 200) begin tick(); n++; end
    vectors++;
    if (cmd_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL cmd_accept: cmd_rdy=%b required 1 (addr %h)", cmd_rdy, a);
    end
    tick();
    cmd_vld = 1'b0;
  endtask

  task automatic pop_rsp(input logic ew, input logic [31:0] ed, input logic ee);
    int n = 0;
    while (!rsp_vld && n < 100) begin tick(); n++; end
    vectors++;
    if (rsp_vld !== 1'b1 || rsp_write !== ew || rsp_rdata !== ed || rsp_err !== ee) begin
      miscompares++;
      $display("FAIL rsp: vld=%b w=%b d=%h e=%b required vld=1 w=%b d=%h e=%b",
               rsp_vld, rsp_write, rsp_rdata, rsp_err, ew, ed, ee);
    end
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(); tick();
    vectors++;
    if (psel !== 1'b0 || penable !== 1'b0 || rsp_vld !== 1'b0 || busy !== 1'b0 ||
        paddr !== 12'h000 || pwdata !== 32'h0 || pstrb !== 4'h0 || pwrite !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: psel=%b pen=%b rsp_vld=%b busy=%b paddr=%h required all 0",
               psel, penable, rsp_vld, busy, paddr);
    end
    rstn = 1'b1;
    tick();
    vectors++;
    if (cmd_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_cmd_rdy: got %b required 1", cmd_rdy);
    end
  endtask

  task automatic test_write();
    slv_ws = 0; slv_fixed = 1'b0;
    send_cmd(1'b1, 12'h010, 32'hA5A5_5A5A, 4'hF);
    vectors++;
    if (psel !== 1'b0) begin miscompares++; $display("FAIL wr_cycle0_psel: got %b required 0", psel); end
    tick();
    vectors++;
    if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 12'h010 || pwrite !== 1'b1 ||
        pwdata !== 32'hA5A5_5A5A || pstrb !== 4'hF) begin
      miscompares++;
      $display("FAIL wr_setup: psel=%b pen=%b paddr=%h pwrite=%b pwdata=%h pstrb=%h required 1 0 010 1 a5a55a5a f",
               psel, penable, paddr, pwrite, pwdata, pstrb);
    end
    tick();
    vectors++;
    if (psel !== 1'b1 || penable !== 1'b1 || rsp_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_access: psel=%b pen=%b rsp_vld=%b required 1 1 0", psel, penable, rsp_vld);
    end
    tick();
    vectors++;
    if (rsp_vld !== 1'b1 || rsp_write !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || psel !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_rsp: vld=%b w=%b e=%b d=%h psel=%b required 1 1 0 0 0",
               rsp_vld, rsp_write, rsp_err, rsp_rdata, psel);
    end
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    vectors++;
    if (rsp_vld !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_drained: rsp_vld=%b busy=%b required 0 0", rsp_vld, busy);
    end
  endtask

  task automatic test_wait_states();
    int acc = 0;
    logic unstable = 1'b0;
    slv_ws = 3; slv_fixed = 1'b1; slv_rdata = 32'h1234_5678;
    send_cmd(1'b0, 12'h020, 32'hFFFF_FFFF, 4'hF);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (psel && penable) begin
        acc++;
        if (paddr !== 12'h020 || pwrite !== 1'b0 || pstrb !== 4'h0) unstable = 1'b1;
      end
      if (rsp_vld) break;
    end
    vectors++;
    if (acc !== 4 || unstable !== 1'b0) begin
      miscompares++;
      $display("FAIL ws_access: access_cycles=%0d unstable=%b required 4 0", acc, unstable);
    end
    pop_rsp(1'b0, 32'h1234_5678, 1'b0);
    slv_ws = 0; slv_fixed = 1'b0;
  endtask

  task automatic test_slverr();
    slv_err = 1'b1;
    send_cmd(1'b0, 12'h044, 32'h0, 4'hF);
    pop_rsp(1'b0, 32'hDA7A_0044, 1'b1);
    slv_err = 1'b0;
    send_cmd(1'b1, 12'h048, 32'h0000_0048, 4'h3);
    pop_rsp(1'b1, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int got = 0;
    int gaps = 0;
    logic started = 1'b0;
    logic [11:0] a;
    logic [31:0] ed;
    log_addr.delete(); log_write.delete();
    rsp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 12'h100 + 12'(i * 16);
      send_cmd(i[0], a, 32'hB000_0000 + 32'(i), 4'hF);
    end
    repeat (12) tick();
    vectors++;
    if (log_addr.size() !== 2 || psel !== 1'b0 || rsp_vld !== 1'b1 || busy !== 1'b1 || cmd_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_park: transfers=%0d psel=%b rsp_vld=%b busy=%b cmd_rdy=%b required 2 0 1 1 1",
               log_addr.size(), psel, rsp_vld, busy, cmd_rdy);
    end
    for (int i = 4; i < 6; i++) begin
      a = 12'h100 + 12'(i * 16);
      send_cmd(i[0], a, 32'hB000_0000 + 32'(i), 4'hF);
    end
    vectors++;
    if (cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL bp_full: cmd_rdy=%b required 0", cmd_rdy); end
    rsp_rdy = 1'b1;
    for (int n = 0; n < 60 && got < 6; n++) begin
      if (psel) started = 1'b1;
      if (started && !psel && log_addr.size() < 6) gaps++;
      if (rsp_vld) begin
        a  = 12'h100 + 12'(got * 16);
        ed = got[0] ? 32'h0 : {20'hDA7A0, a};
        vectors++;
        if (rsp_write !== got[0] || rsp_rdata !== ed || rsp_err !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_rsp%0d: w=%b d=%h e=%b required %b %h 0", got, rsp_write, rsp_rdata, rsp_err, got[0], ed);
        end
        got++;
      end
      tick();
    end
    rsp_rdy = 1'b0;
    vectors++;
    if (got !== 6 || gaps !== 0 || log_addr.size() !== 6) begin
      miscompares++;
      $display("FAIL bp_drain: responses=%0d psel_gaps=%0d transfers=%0d required 6 0 6", got, gaps, log_addr.size());
    end
    for (int i = 0; i < log_addr.size() && i < 6; i++) begin
      a = 12'h100 + 12'(i * 16);
      vectors++;
      if (log_addr[i] !== a || log_write[i] !== i[0]) begin
        miscompares++;
        $display("FAIL bp_order%0d: addr=%h w=%b required %h %b", i, log_addr[i], log_write[i], a, i[0]);
      end
    end
  endtask

  task automatic test_fill_stall();
    int got = 0;
    logic [11:0] a;
    log_addr.delete(); log_write.delete();
    slv_stall = 1'b1; rsp_rdy = 1'b0;
    send_cmd(1'b0, 12'h200, 32'h0, 4'hF);
    repeat (3) tick();
    vectors++;
    if (psel !== 1'b1 || penable !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_stalled: psel=%b pen=%b required 1 1", psel, penable);
    end
    for (int i = 1; i < 5; i++) send_cmd(1'b0, 12'h200 + 12'(i * 16), 32'h0, 4'hF);
    vectors++;
    if (cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL fill_full: cmd_rdy=%b required 0", cmd_rdy); end
    cmd_addr = 12'h3F0; cmd_vld = 1'b1;
    repeat (3) tick();
    cmd_vld = 1'b0;
    slv_stall = 1'b0; rsp_rdy = 1'b1;
    for (int n = 0; n < 80; n++) begin
      if (rsp_vld) begin
        a = 12'h200 + 12'(got * 16);
        vectors++;
        if (rsp_rdata !== {20'hDA7A0, a} || rsp_write !== 1'b0 || rsp_err !== 1'b0) begin
          miscompares++;
          $display("FAIL fill_rsp%0d: d=%h w=%b e=%b required %h 0 0", got, rsp_rdata, rsp_write, rsp_err, {20'hDA7A0, a});
        end
        got++;
      end
      if (!busy) break;
      tick();
    end
    rsp_rdy = 1'b0;
    vectors++;
    if (got !== 5 || log_addr.size() !== 5 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_count: responses=%0d transfers=%0d busy=%b required 5 5 0", got, log_addr.size(), busy);
    end
  endtask

`ifdef APB_MST_TIMEOUT_EN
  task automatic test_timeout();
    int acc = 0;
    slv_stall = 1'b1;
    send_cmd(1'b1, 12'h0A0, 32'h0000_00A0, 4'hF);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (psel && penable) acc++;
      if (rsp_vld) break;
    end
    vectors++;
    if (acc !== 8 || psel !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_cycles: access_cycles=%0d psel=%b required 8 0", acc, psel);
    end
    pop_rsp(1'b1, 32'h0, 1'b1);
    slv_stall = 1'b0;
    send_cmd(1'b0, 12'h0B0, 32'h0, 4'hF);
    pop_rsp(1'b0, 32'hDA7A_00B0, 1'b0);
  endtask
`endif

  task automatic test_reset_mid();
    slv_stall = 1'b1;
    send_cmd(1'b1, 12'h0C0, 32'hC0C0_C0C0, 4'hF);
    repeat (3) tick();
    vectors++;
    if (penable !== 1'b1) begin miscompares++; $display("FAIL rm_access: penable=%b required 1", penable); end
    rstn = 1'b0;
    #1;
    vectors++;
    if (psel !== 1'b0 || penable !== 1'b0 || paddr !== 12'h000 || pwdata !== 32'h0 ||
        pstrb !== 4'h0 || pwrite !== 1'b0 || rsp_vld !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rm_outputs: psel=%b pen=%b paddr=%h pwdata=%h rsp_vld=%b busy=%b required all 0",
               psel, penable, paddr, pwdata, rsp_vld, busy);
    end
    tick();
    rstn = 1'b1;
    slv_stall = 1'b0;
    repeat (5) tick();
    vectors++;
    if (rsp_vld !== 1'b0 || psel !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rm_no_rsp: rsp_vld=%b psel=%b busy=%b required 0 0 0", rsp_vld, psel, busy);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wait_states();
    test_slverr();
    test_back_to_back();
    test_fill_stall();
`ifdef APB_MST_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
